mux4_rr_packet: RTL and testbench

- 4-to-1 packet multiplexer: the merging counterpart to the 1:4 demultiplexer.
- Collects packets from four valid/ready input channels and emits them one packet at a time on a single registered output stream.
- Tags every output beat with the 2-bit source index (out_sel), so a downstream 1:4 demux can route it back by select.
- Arbitration is round-robin at packet granularity; a granted channel keeps the output until its last beat.

---
 rtl/mux_pkg.sv | 28 ++
 rtl/rr_arb4.sv | 13 +
 rtl/mux4_rr_packet.sv | 110 +++++++++++
 tb/tb_mux4_rr_packet.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants, FSM state type and round-robin pick function
package mux_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Returns {found, idx}. The loop runs from the farthest offset down, so the
    // channel closest to ptr is the one left in pick.
    function automatic logic [SELW:0] rr_pick(input logic [NCH-1:0]  valid,
                                              input logic [SELW-1:0] ptr);
        logic [SELW:0]   pick;
        logic [SELW-1:0] idx;
        pick = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = ptr + SELW'(i);
            if (valid[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - combinational 4-way round-robin picker
module rr_arb4
    import mux_pkg::*;
(
    input  logic [NCH-1:0]  valid_i,
    input  logic [SELW-1:0] ptr_i,
    output logic            found_o,
    output logic [SELW-1:0] idx_o
);

    assign {found_o, idx_o} = rr_pick(valid_i, ptr_i);

endmodule

// File: rtl/mux4_rr_packet.sv
// rtl/mux4_rr_packet.sv - 4:1 packet mux, round-robin per packet, registered tagged output
module mux4_rr_packet
    import mux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      in_valid,
    input  logic [NCH-1:0]      in_last,
    input  logic [NCH*DW-1:0]   in_data,
    output logic [NCH-1:0]      in_ready,
    output logic                out_valid,
    output logic                out_last,
    output logic [DW-1:0]       out_data,
    output logic [SELW-1:0]     out_sel,
    input  logic                out_ready
);

    state_e          state_q, state_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SELW-1:0] lock_ch_q, lock_ch_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [SELW-1:0] out_sel_q, out_sel_d;

    logic            arb_found;
    logic [SELW-1:0] arb_idx;
    logic            load_en;
    logic            grant_vld;
    logic [SELW-1:0] grant_ch;
    logic            accept;
    logic            beat_last;
    logic [DW-1:0]   beat_data;

    rr_arb4 u_arb (
        .valid_i (in_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (arb_found),
        .idx_o   (arb_idx)
    );

    assign load_en = !out_valid_q || out_ready;

    // in_ready is gated by rst so nothing is offered while reset is held.
    always_comb begin
        grant_ch  = (state_q == LOCKED) ? lock_ch_q : arb_idx;
        grant_vld = (state_q == LOCKED) || arb_found;
        in_ready  = '0;
        if (!rst && grant_vld) begin
            in_ready[grant_ch] = load_en;
        end
    end

    assign accept    = |(in_valid & in_ready);
    assign beat_last = in_last[grant_ch];
    assign beat_data = in_data[grant_ch*DW +: DW];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_ch_d   = lock_ch_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_last_d  = beat_last;
            out_data_d  = beat_data;
            out_sel_d   = grant_ch;
            if (beat_last) begin
                rr_ptr_d = grant_ch + SELW'(1);
                state_d  = ARB;
            end else begin
                lock_ch_d = grant_ch;
                state_d   = LOCKED;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            lock_ch_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_ch_q   <= lock_ch_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4_rr_packet.sv
// tb/tb_mux4_rr_packet.sv - scoreboard bench for mux4_rr_packet
module tb_mux4_rr_packet;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    in_valid;
    logic [3:0]    in_last;
    logic [4*DW-1:0] in_data;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic          out_last;
    logic [DW-1:0] out_data;
    logic [1:0]    out_sel;
    logic          out_ready;

    int errors = 0;
    int checks = 0;

    // Source beat: {gap_before[3:0], last, data[7:0]}; expected beat: {sel, last, data}.
    logic [12:0] src_q[4][$];
    int          gap_cnt[4];
    logic [10:0] exp_q[$];
    logic        stall_q = 1'b0;
    logic [10:0] held;
    int          ncyc;

    mux4_rr_packet #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_src(input int ch, input logic [7:0] d, input logic l, input int gap);
        if (src_q[ch].size() == 0) gap_cnt[ch] = gap;
        src_q[ch].push_back({4'(gap), l, d});
    endtask

    task automatic expect_beat(input logic [1:0] s, input logic [7:0] d, input logic l);
        exp_q.push_back({s, l, d});
    endtask

    task automatic drive();
        logic [12:0] h;
        for (int k = 0; k < 4; k++) begin
            if (src_q[k].size() > 0 && gap_cnt[k] == 0) begin
                h = src_q[k][0];
                in_valid[k]        = 1'b1;
                in_last[k]         = h[8];
                in_data[k*DW +: DW] = h[7:0];
            end else begin
                in_valid[k]        = 1'b0;
                in_last[k]         = 1'b0;
                in_data[k*DW +: DW] = 8'h00;
            end
        end
    endtask

    // One cycle: drive after the edge, sample mid-cycle, then retire accepted source beats.
    task automatic step();
        logic [3:0]  acc;
        logic [10:0] beat;
        logic [10:0] e;
        logic [12:0] h;
        drive();
        #4;
        chk("ready_onehot", 32'($onehot0(in_ready)), 32'd1);
        beat = {out_sel, out_last, out_data};
        if (out_valid && !out_ready) begin
            chk("bp_ready", 32'(in_ready), 32'd0);
            if (stall_q) chk("bp_hold", 32'(beat), 32'(held));
            held    = beat;
            stall_q = 1'b1;
        end else begin
            stall_q = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'(beat), 32'h7ff);
            end else begin
                e = exp_q.pop_front();
                chk("beat", 32'(beat), 32'(e));
            end
        end
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (acc[k]) begin
                void'(src_q[k].pop_front());
                if (src_q[k].size() > 0) begin
                    h = src_q[k][0];
                    gap_cnt[k] = int'(h[12:9]);
                end
            end else if (gap_cnt[k] > 0) begin
                gap_cnt[k]--;
            end
        end
    endtask

    task automatic run_until(input string tag, input int budget, output int n);
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_src_empty"}, 32'(src_q[k].size()), 32'd0);
        end
    endtask

    initial begin
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        for (int k = 0; k < 4; k++) gap_cnt[k] = 0;
        #1 rst = 1'b1;

        // Reset with every channel valid
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                push_src(k, 8'hA0 + 8'(k), 1'b1, 0);
                expect_beat(2'(k), 8'hA0 + 8'(k), 1'b1);
            end
        end
        @(posedge clk);
        #1;
        drive();
        #3;
        chk("rst_in_valid_all", 32'(in_valid), 32'hF);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-beat round robin from ch0, full throughput
        run_until("rr", 40, ncyc);
        chk("rr_cycles", 32'(ncyc), 32'd9);

        // Steer pointer to 2 with a lone ch1 packet, then lock on ch2
        push_src(1, 8'h10, 1'b1, 0);
        expect_beat(2'd1, 8'h10, 1'b1);
        run_until("pre_lock", 20, ncyc);
        push_src(2, 8'h21, 1'b0, 0);
        push_src(2, 8'h22, 1'b0, 0);
        push_src(2, 8'h23, 1'b1, 0);
        push_src(0, 8'h01, 1'b1, 0);
        push_src(1, 8'h11, 1'b1, 0);
        expect_beat(2'd2, 8'h21, 1'b0);
        expect_beat(2'd2, 8'h22, 1'b0);
        expect_beat(2'd2, 8'h23, 1'b1);
        expect_beat(2'd0, 8'h01, 1'b1);
        expect_beat(2'd1, 8'h11, 1'b1);
        run_until("lock", 40, ncyc);

        // Backpressure mid-stream (pointer at 2)
        push_src(2, 8'h31, 1'b0, 0);
        push_src(2, 8'h32, 1'b1, 0);
        push_src(3, 8'h41, 1'b1, 0);
        push_src(0, 8'h51, 1'b1, 0);
        expect_beat(2'd2, 8'h31, 1'b0);
        expect_beat(2'd2, 8'h32, 1'b1);
        expect_beat(2'd3, 8'h41, 1'b1);
        expect_beat(2'd0, 8'h51, 1'b1);
        step();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("bp_stalled", 32'(stall_q), 32'd1);
        out_ready = 1'b1;
        run_until("bp", 40, ncyc);

        // Gap inside a locked ch1 packet with ch3 waiting (pointer at 1)
        push_src(1, 8'h61, 1'b0, 0);
        push_src(1, 8'h62, 1'b0, 3);
        push_src(1, 8'h63, 1'b1, 0);
        push_src(3, 8'h71, 1'b1, 0);
        expect_beat(2'd1, 8'h61, 1'b0);
        expect_beat(2'd1, 8'h62, 1'b0);
        expect_beat(2'd1, 8'h63, 1'b1);
        expect_beat(2'd3, 8'h71, 1'b1);
        run_until("gap", 40, ncyc);

        // Reset during ch0 beat 2 of 4
        push_src(0, 8'h81, 1'b0, 0);
        push_src(0, 8'h82, 1'b0, 0);
        push_src(0, 8'h83, 1'b0, 0);
        push_src(0, 8'h84, 1'b1, 0);
        expect_beat(2'd0, 8'h81, 1'b0);
        step();
        step();
        chk("pre_rst_exp", 32'(exp_q.size()), 32'd0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_sel", 32'(out_sel), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        for (int k = 0; k < 4; k++) begin
            src_q[k].delete();
            gap_cnt[k] = 0;
        end
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_src(1, 8'h91, 1'b0, 0);
        push_src(1, 8'h92, 1'b1, 0);
        push_src(3, 8'hB1, 1'b1, 0);
        expect_beat(2'd1, 8'h91, 1'b0);
        expect_beat(2'd1, 8'h92, 1'b1);
        expect_beat(2'd3, 8'hB1, 1'b1);
        run_until("post_rst", 40, ncyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
